// File: rtl/alu_share_arbiter_if.sv
// Bundle of the client request/response handshakes and the shared ALU port.
// The arbiter takes the slave view; clients and the external ALU take the master view.
interface alu_share_arbiter_if #(
  parameter int WIDTH = 32
);

  logic             req0_valid;
  logic             req0_ready;
  logic [1:0]       req0_aluop;
  logic             req0_fun7;
  logic [2:0]       req0_fun3;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;

  logic             req1_valid;
  logic             req1_ready;
  logic [1:0]       req1_aluop;
  logic             req1_fun7;
  logic [2:0]       req1_fun3;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;

  logic             rsp0_valid;
  logic             rsp0_ready;
  logic             rsp1_valid;
  logic             rsp1_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_err;

  logic [3:0]       alu_ctrl;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             alu_issue;
  logic [WIDTH-1:0] alu_result;

  modport slave (
    input  req0_valid, req0_aluop, req0_fun7, req0_fun3, req0_a, req0_b,
    input  req1_valid, req1_aluop, req1_fun7, req1_fun3, req1_a, req1_b,
    input  rsp0_ready, rsp1_ready, alu_result,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data, rsp_err,
    output alu_ctrl, alu_a, alu_b, alu_issue
  );

  modport master (
    output req0_valid, req0_aluop, req0_fun7, req0_fun3, req0_a, req0_b,
    output req1_valid, req1_aluop, req1_fun7, req1_fun3, req1_a, req1_b,
    output rsp0_ready, rsp1_ready, alu_result,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data, rsp_err,
    input  alu_ctrl, alu_a, alu_b, alu_issue
  );

endinterface

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two clients. A request is granted in IDLE,
// decoded into a 4-bit ALU control code, issued for one cycle, and the captured
// result is held in RESP until the granted client takes it. Illegal encodings are
// still accepted but skip the ALU and come back with an error flag.
module alu_share_arbiter #(
  parameter int WIDTH      = 32,
  parameter bit PRIO_FIXED = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_share_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arbState_t;

  arbState_t        r_state;
  arbState_t        w_nextState;

  logic             r_grant;
  logic             r_lastGrant;
  logic [WIDTH-1:0] r_aluA;
  logic [WIDTH-1:0] r_aluB;
  logic [3:0]       r_aluCtrl;
  logic [WIDTH-1:0] r_rspData;
  logic             r_rspErr;

  logic             w_anyValid;
  logic             w_winner;
  logic             w_accept;
  logic             w_legal;
  logic             w_rspReady;
  logic [1:0]       w_selOp;
  logic             w_selF7;
  logic [2:0]       w_selF3;
  logic [WIDTH-1:0] w_selA;
  logic [WIDTH-1:0] w_selB;
  logic [3:0]       w_ctrl;
  logic             w_req0Ready;
  logic             w_req1Ready;
  logic             w_rsp0Valid;
  logic             w_rsp1Valid;
  logic             w_aluIssue;

  // Pick the winner: a lone requester wins, contention goes by fixed priority or to the client not served last.
  always_comb begin
    w_anyValid = bus.req0_valid | bus.req1_valid;
    w_winner   = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      w_winner = PRIO_FIXED ? 1'b0 : ~r_lastGrant;
    end else if (bus.req1_valid) begin
      w_winner = 1'b1;
    end
  end

  // Route the winning client's request fields to the decoder and operand latches.
  always_comb begin
    if (w_winner) begin
      w_selOp = bus.req1_aluop;
      w_selF7 = bus.req1_fun7;
      w_selF3 = bus.req1_fun3;
      w_selA  = bus.req1_a;
      w_selB  = bus.req1_b;
    end else begin
      w_selOp = bus.req0_aluop;
      w_selF7 = bus.req0_fun7;
      w_selF3 = bus.req0_fun3;
      w_selA  = bus.req0_a;
      w_selB  = bus.req0_b;
    end
  end

  // Map {ALUop,fun7,fun3} to the ALU control code; anything not listed is illegal.
  always_comb begin
    w_ctrl  = 4'b0000;
    w_legal = 1'b0;
    case ({w_selOp, w_selF7, w_selF3})
      6'b00_0_000: begin w_ctrl = 4'b0010; w_legal = 1'b1; end
      6'b01_0_000: begin w_ctrl = 4'b0110; w_legal = 1'b1; end
      6'b10_0_000: begin w_ctrl = 4'b0010; w_legal = 1'b1; end
      6'b10_1_000: begin w_ctrl = 4'b0110; w_legal = 1'b1; end
      6'b10_1_111: begin w_ctrl = 4'b0000; w_legal = 1'b1; end
      6'b10_1_110: begin w_ctrl = 4'b0001; w_legal = 1'b1; end
      default:     begin w_ctrl = 4'b0000; w_legal = 1'b0; end
    endcase
  end

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic plus the handshake outputs that follow directly from the state.
  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    w_req0Ready = 1'b0;
    w_req1Ready = 1'b0;
    w_rsp0Valid = 1'b0;
    w_rsp1Valid = 1'b0;
    w_aluIssue  = 1'b0;
    w_rspReady  = r_grant ? bus.rsp1_ready : bus.rsp0_ready;
    case (r_state)
      IDLE: begin
        if (w_anyValid && rst_n) begin
          w_accept    = 1'b1;
          w_req0Ready = ~w_winner;
          w_req1Ready = w_winner;
          w_nextState = w_legal ? ISSUE : RESP;
        end
      end
      ISSUE: begin
        w_aluIssue  = 1'b1;
        w_nextState = RESP;
      end
      RESP: begin
        w_rsp0Valid = ~r_grant;
        w_rsp1Valid = r_grant;
        if (w_rspReady) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Latch grant and ALU inputs on acceptance, then capture the ALU result (or the error) for the response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_grant     <= 1'b0;
      r_lastGrant <= 1'b1;
      r_aluA      <= '0;
      r_aluB      <= '0;
      r_aluCtrl   <= 4'b0000;
      r_rspData   <= '0;
      r_rspErr    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_grant     <= w_winner;
        r_lastGrant <= w_winner;
        if (w_legal) begin
          r_aluA    <= w_selA;
          r_aluB    <= w_selB;
          r_aluCtrl <= w_ctrl;
        end else begin
          r_rspData <= '0;
          r_rspErr  <= 1'b1;
        end
      end
      if (r_state == ISSUE) begin
        r_rspData <= bus.alu_result;
        r_rspErr  <= 1'b0;
      end
    end
  end

  assign bus.req0_ready = w_req0Ready;
  assign bus.req1_ready = w_req1Ready;
  assign bus.rsp0_valid = w_rsp0Valid;
  assign bus.rsp1_valid = w_rsp1Valid;
  assign bus.rsp_data   = r_rspData;
  assign bus.rsp_err    = r_rspErr;
  assign bus.alu_ctrl   = r_aluCtrl;
  assign bus.alu_a      = r_aluA;
  assign bus.alu_b      = r_aluB;
  assign bus.alu_issue  = w_aluIssue;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed cases followed by random
// request traffic, compared against a transaction-level model of grant order,
// decode table, ALU arithmetic and response timing.
module tb_alu_share_arbiter;

  localparam int WIDTH   = 32;
  localparam bit TB_PRIO = 1'b0;

  logic clk = 1'b0;
  logic rst_n;

  alu_share_arbiter_if #(.WIDTH(WIDTH)) bus ();

  alu_share_arbiter #(
    .WIDTH      (WIDTH),
    .PRIO_FIXED (TB_PRIO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // 10-unit clock.
  always #5 clk = ~clk;

  logic [WIDTH-1:0] aluOut;

  // External combinational ALU: add, sub, and, or.
  always_comb begin
    aluOut = '0;
    case (bus.alu_ctrl)
      4'b0010: aluOut = bus.alu_a + bus.alu_b;
      4'b0110: aluOut = bus.alu_a - bus.alu_b;
      4'b0000: aluOut = bus.alu_a & bus.alu_b;
      4'b0001: aluOut = bus.alu_a | bus.alu_b;
      default: aluOut = '0;
    endcase
  end
  assign bus.alu_result = aluOut;

  int numVectors     = 0;
  int numMiscompares = 0;

  logic             pendValid [2];
  logic [1:0]       pendOp    [2];
  logic             pendF7    [2];
  logic [2:0]       pendF3    [2];
  logic [WIDTH-1:0] pendA     [2];
  logic [WIDTH-1:0] pendB     [2];
  int               lastGrantM;
  logic [WIDTH-1:0] lastA;
  logic [WIDTH-1:0] lastB;
  logic [3:0]       lastCtrl;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    numVectors++;
    if (got !== exp) begin
      numMiscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic refEval(input logic [1:0] op, input logic f7, input logic [2:0] f3,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         output logic err, output logic [3:0] ctrl, output logic [WIDTH-1:0] res);
    err  = 1'b0;
    ctrl = 4'b0000;
    res  = '0;
    if ((op == 2'd0 || op == 2'd2) && !f7 && f3 == 3'd0) begin
      ctrl = 4'b0010; res = a + b;
    end else if ((op == 2'd1 && !f7 && f3 == 3'd0) || (op == 2'd2 && f7 && f3 == 3'd0)) begin
      ctrl = 4'b0110; res = a - b;
    end else if (op == 2'd2 && f7 && f3 == 3'd7) begin
      ctrl = 4'b0000; res = a & b;
    end else if (op == 2'd2 && f7 && f3 == 3'd6) begin
      ctrl = 4'b0001; res = a | b;
    end else begin
      err = 1'b1;
    end
  endtask

  task automatic driveReqs();
    bus.req0_valid = pendValid[0];
    bus.req0_aluop = pendOp[0];
    bus.req0_fun7  = pendF7[0];
    bus.req0_fun3  = pendF3[0];
    bus.req0_a     = pendA[0];
    bus.req0_b     = pendB[0];
    bus.req1_valid = pendValid[1];
    bus.req1_aluop = pendOp[1];
    bus.req1_fun7  = pendF7[1];
    bus.req1_fun3  = pendF3[1];
    bus.req1_a     = pendA[1];
    bus.req1_b     = pendB[1];
  endtask

  task automatic setReq(input int c, input logic [1:0] op, input logic f7, input logic [2:0] f3,
                        input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    pendValid[c] = 1'b1;
    pendOp[c]    = op;
    pendF7[c]    = f7;
    pendF3[c]    = f3;
    pendA[c]     = a;
    pendB[c]     = b;
  endtask

  task automatic newRandReq(input int c);
    int k;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    k = $urandom_range(0, 7);
    a = WIDTH'($urandom);
    b = WIDTH'($urandom);
    case (k)
      0: setReq(c, 2'd0, 1'b0, 3'd0, a, b);
      1: setReq(c, 2'd1, 1'b0, 3'd0, a, b);
      2: setReq(c, 2'd2, 1'b0, 3'd0, a, b);
      3: setReq(c, 2'd2, 1'b1, 3'd0, a, b);
      4: setReq(c, 2'd2, 1'b1, 3'd7, a, b);
      5: setReq(c, 2'd2, 1'b1, 3'd6, a, b);
      6: setReq(c, 2'd3, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, b);
      default: setReq(c, 2'd2, 1'b0, 3'($urandom_range(1, 7)), a, b);
    endcase
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_req_ready"}, 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
    checkOutput({tag, "_rsp_valid"}, 32'({bus.rsp1_valid, bus.rsp0_valid}), 32'd0);
    checkOutput({tag, "_alu_issue"}, 32'(bus.alu_issue), 32'd0);
    checkOutput({tag, "_rsp_err"},   32'(bus.rsp_err), 32'd0);
    checkOutput({tag, "_rsp_data"},  32'(bus.rsp_data), 32'd0);
    checkOutput({tag, "_alu_ctrl"},  32'(bus.alu_ctrl), 32'd0);
    checkOutput({tag, "_alu_a"},     32'(bus.alu_a), 32'd0);
    checkOutput({tag, "_alu_b"},     32'(bus.alu_b), 32'd0);
  endtask

  task automatic applyReset();
    rst_n           = 1'b0;
    pendValid[0]    = 1'b0;
    pendValid[1]    = 1'b0;
    driveReqs();
    bus.rsp0_ready  = 1'b0;
    bus.rsp1_ready  = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkResetValues("reset");
    rst_n      = 1'b1;
    lastGrantM = 1;
    lastA      = '0;
    lastB      = '0;
    lastCtrl   = 4'b0000;
  endtask

  // One full transaction from IDLE: grant, optional ISSUE, RESP held for 'hold' extra cycles, then handshake.
  task automatic applyStimulus(input int hold);
    int               w;
    logic             expErr;
    logic [3:0]       expCtrl;
    logic [WIDTH-1:0] expRes;
    @(negedge clk);
    driveReqs();
    #1;
    checkOutput("rsp_valid_idle", 32'({bus.rsp1_valid, bus.rsp0_valid}), 32'd0);
    checkOutput("alu_issue_idle", 32'(bus.alu_issue), 32'd0);
    if (pendValid[0] && pendValid[1]) w = TB_PRIO ? 0 : 1 - lastGrantM;
    else if (pendValid[1])            w = 1;
    else                              w = 0;
    checkOutput("req0_ready", 32'(bus.req0_ready), 32'(w == 0 && pendValid[0]));
    checkOutput("req1_ready", 32'(bus.req1_ready), 32'(w == 1 && pendValid[1]));
    refEval(pendOp[w], pendF7[w], pendF3[w], pendA[w], pendB[w], expErr, expCtrl, expRes);
    lastGrantM   = w;
    pendValid[w] = 1'b0;
    @(negedge clk);
    driveReqs();
    #1;
    checkOutput("req_ready_busy", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
    if (!expErr) begin
      checkOutput("alu_issue", 32'(bus.alu_issue), 32'd1);
      checkOutput("alu_ctrl", 32'(bus.alu_ctrl), 32'(expCtrl));
      checkOutput("alu_a", 32'(bus.alu_a), 32'(pendA[w]));
      checkOutput("alu_b", 32'(bus.alu_b), 32'(pendB[w]));
      checkOutput("rsp_valid_issue", 32'({bus.rsp1_valid, bus.rsp0_valid}), 32'd0);
      lastA    = pendA[w];
      lastB    = pendB[w];
      lastCtrl = expCtrl;
      @(negedge clk);
      #1;
    end
    checkOutput("alu_issue_resp", 32'(bus.alu_issue), 32'd0);
    checkOutput("alu_a_hold", 32'(bus.alu_a), 32'(lastA));
    checkOutput("alu_b_hold", 32'(bus.alu_b), 32'(lastB));
    checkOutput("alu_ctrl_hold", 32'(bus.alu_ctrl), 32'(lastCtrl));
    for (int h = 0; h <= hold; h++) begin
      if (h > 0) begin
        @(negedge clk);
        #1;
      end
      checkOutput("rsp0_valid", 32'(bus.rsp0_valid), 32'(w == 0));
      checkOutput("rsp1_valid", 32'(bus.rsp1_valid), 32'(w == 1));
      checkOutput("rsp_data", 32'(bus.rsp_data), 32'(expRes));
      checkOutput("rsp_err", 32'(bus.rsp_err), 32'(expErr));
      checkOutput("req_ready_resp", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
    end
    if (w == 0) bus.rsp0_ready = 1'b1;
    else        bus.rsp1_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
  endtask

  // Reset asserted while a legal operation sits in ISSUE; the op must vanish.
  task automatic resetMidOp();
    pendValid[1] = 1'b0;
    setReq(0, 2'd2, 1'b1, 3'd0, WIDTH'($urandom), WIDTH'($urandom));
    @(negedge clk);
    driveReqs();
    #1;
    checkOutput("midrst_accept", 32'(bus.req0_ready), 32'd1);
    pendValid[0] = 1'b0;
    @(negedge clk);
    driveReqs();
    #1;
    checkOutput("midrst_issue", 32'(bus.alu_issue), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    checkResetValues("midrst");
    rst_n      = 1'b1;
    lastGrantM = 1;
    lastA      = '0;
    lastB      = '0;
    lastCtrl   = 4'b0000;
    @(negedge clk);
    #1;
    checkOutput("midrst_no_rsp", 32'({bus.rsp1_valid, bus.rsp0_valid}), 32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int c = 0; c < 2; c++) begin
      pendValid[c] = 1'b0;
      pendOp[c]    = 2'd0;
      pendF7[c]    = 1'b0;
      pendF3[c]    = 3'd0;
      pendA[c]     = '0;
      pendB[c]     = '0;
    end
    applyReset();

    setReq(0, 2'd2, 1'b0, 3'd0, 32'd5, 32'd3);
    applyStimulus(0);
    setReq(1, 2'd1, 1'b0, 3'd0, 32'd3, 32'd5);
    applyStimulus(0);
    setReq(1, 2'd3, 1'b0, 3'd0, WIDTH'($urandom), WIDTH'($urandom));
    applyStimulus(1);
    setReq(0, 2'd2, 1'b1, 3'd7, 32'hF0F0_1234, 32'h0FF0_FFFF);
    setReq(1, 2'd2, 1'b1, 3'd6, 32'h1111_0000, 32'h0000_2222);
    applyStimulus(5);
    applyStimulus(0);

    applyReset();
    for (int i = 0; i < 4; i++) begin
      for (int c = 0; c < 2; c++) begin
        if (!pendValid[c]) newRandReq(c);
      end
      applyStimulus(0);
    end
    applyStimulus(0);

    resetMidOp();
    setReq(0, 2'd0, 1'b0, 3'd0, 32'd100, 32'd23);
    applyStimulus(0);

    for (int n = 0; n < 60; n++) begin
      for (int c = 0; c < 2; c++) begin
        if (!pendValid[c] && $urandom_range(0, 3) != 0) newRandReq(c);
      end
      if (!pendValid[0] && !pendValid[1]) begin
        @(negedge clk);
        driveReqs();
        #1;
        checkOutput("idle_no_grant", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
        checkOutput("idle_no_rsp", 32'({bus.rsp1_valid, bus.rsp0_valid}), 32'd0);
      end else begin
        applyStimulus($urandom_range(0, 3));
      end
    end

    @(negedge clk);
    pendValid[0] = 1'b0;
    pendValid[1] = 1'b0;
    driveReqs();
    #1;
    checkOutput("final_rsp_valid", 32'({bus.rsp1_valid, bus.rsp0_valid}), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", numVectors, numMiscompares);
    $finish;
  end

endmodule
